// File: rtl/alu_sequencer.sv
// Command sequencer that drives an external ALU from a 4-entry register bank, one command at a time.
// Optional conditional execution against the stored flags is enabled by defining ALU_SEQ_COND_EXEC_EN.
module alu_sequencer #(
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic [4:0]        CmdFunSel,
  input  logic [1:0]        CmdDst,
  input  logic [1:0]        CmdSrcA,
  input  logic [1:0]        CmdSrcB,
  input  logic [1:0]        CmdCond,
  input  logic              RegWrEn,
  input  logic [1:0]        RegWrAddr,
  input  logic [DATA_W-1:0] RegWrData,
  output logic [DATA_W-1:0] AluA,
  output logic [DATA_W-1:0] AluB,
  output logic [4:0]        AluFunSel,
  output logic              AluWF,
  input  logic [DATA_W-1:0] AluOut,
  input  logic [3:0]        AluFlags,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [DATA_W-1:0] RspData,
  output logic [3:0]        RspFlags,
  output logic              RspSkipped
);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, RESP} state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [4];
  logic [3:0]        sf;
  logic [DATA_W-1:0] result;
  logic [1:0]        dst_q;

  logic              accept;
  logic              cond_pass;
  logic [DATA_W-1:0] op_a, op_b, dst_val;

  assign accept = (state == IDLE) && CmdReady && CmdValid;

  // A direct load in the accept cycle is forwarded so the command sees the new value.
  always_comb begin
    op_a    = regs[CmdSrcA];
    op_b    = regs[CmdSrcB];
    dst_val = regs[CmdDst];
    if (RegWrEn && (RegWrAddr == CmdSrcA)) op_a    = RegWrData;
    if (RegWrEn && (RegWrAddr == CmdSrcB)) op_b    = RegWrData;
    if (RegWrEn && (RegWrAddr == CmdDst))  dst_val = RegWrData;
  end

`ifdef ALU_SEQ_COND_EXEC_EN
  // Flag layout: bit 3 Z, bit 2 C, bit 1 N.
  always_comb begin
    cond_pass = 1'b1;
    case (CmdCond)
      2'b01:   cond_pass = sf[3];
      2'b10:   cond_pass = sf[2];
      2'b11:   cond_pass = sf[1];
      default: cond_pass = 1'b1;
    endcase
  end
`else
  logic unused_cond;
  assign unused_cond = ^CmdCond;
  assign cond_pass   = 1'b1;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      sf         <= 4'b0000;
      result     <= '0;
      dst_q      <= 2'b00;
      CmdReady   <= 1'b0;
      AluA       <= '0;
      AluB       <= '0;
      AluFunSel  <= 5'b00000;
      AluWF      <= 1'b0;
      RspValid   <= 1'b0;
      RspData    <= '0;
      RspFlags   <= 4'b0000;
      RspSkipped <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          CmdReady <= 1'b1;
          if (RegWrEn) regs[RegWrAddr] <= RegWrData;
          if (accept) begin
            CmdReady <= 1'b0;
            dst_q    <= CmdDst;
            if (cond_pass) begin
              AluA      <= op_a;
              AluB      <= op_b;
              AluFunSel <= CmdFunSel;
              AluWF     <= 1'b1;
              state     <= DRIVE;
            end else begin
              RspValid   <= 1'b1;
              RspData    <= dst_val;
              RspFlags   <= sf;
              RspSkipped <= 1'b1;
              state      <= RESP;
            end
          end
        end
        // ALU result is combinational on AluOut; flags land in the ALU's own register at this edge.
        DRIVE: begin
          result <= AluOut;
          AluWF  <= 1'b0;
          state  <= CAPTURE;
        end
        CAPTURE: begin
          sf           <= AluFlags;
          regs[dst_q]  <= result;
          RspValid     <= 1'b1;
          RspData      <= result;
          RspFlags     <= AluFlags;
          RspSkipped   <= 1'b0;
          state        <= RESP;
        end
        RESP: begin
          if (RspReady) begin
            RspValid <= 1'b0;
            CmdReady <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
